rc4_decrypt_loop: RTL

- Third stage of the RC4 key-search datapath. Runs after the key-scheduling stage has finished permuting the 256-byte S memory.
- Runs the RC4 pseudo-random generation loop on S: reads S, swaps entries, writes them back, and forms one keystream byte per message byte.
- Each keystream byte is XORed with the encrypted-message ROM byte and written to the decrypted-message RAM.
- Checks every decrypted byte against the plaintext alphabet and aborts early on the first illegal byte, so the key-search controller can move on to the next key.

---
 rtl/rc4_decrypt_loop.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rc4_decrypt_loop.sv
// RC4 pseudo-random generation stage: swaps S entries, XORs keystream with the
// encrypted ROM into the decrypted RAM, aborting on the first non-alphabet byte.
module rc4_decrypt_loop #(
  parameter int MSG_LEN   = 32,
  parameter int READ_WAIT = 2,
  localparam int AW = $clog2(MSG_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_flag,
  output logic          done_flag,
  output logic          key_valid,
  output logic [7:0]    s_address,
  output logic [7:0]    s_data,
  input  logic [7:0]    s_data_read,
  output logic          s_wren,
  output logic [AW-1:0] rom_address,
  input  logic [7:0]    rom_data_read,
  output logic [AW-1:0] dec_address,
  output logic [7:0]    dec_data,
  output logic          dec_wren
);
  // state   | meaning
  // IDLE    | waiting for start_flag, i=j=k=0
  // INC_I   | i <= i+1
  // RD_SI   | drive S[i] address
  // WAIT_SI | S read latency
  // CAP_SI  | capture si
  // SET_J   | j <= j+si
  // RD_SJ   | drive S[j] address
  // WAIT_SJ | S read latency
  // CAP_SJ  | capture sj
  // WR_SI   | S[i] <= sj
  // WR_SJ   | S[j] <= si
  // RD_F    | drive S[si+sj] and ROM[k] addresses
  // WAIT_F  | S/ROM read latency
  // CAP_F   | capture keystream byte f and encrypted byte e
  // WR_DEC  | RAM[k] <= f^e, legality check
  // FINISH  | done_flag/key_valid held until start_flag drops
  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, WAIT_SI, CAP_SI, SET_J, RD_SJ, WAIT_SJ,
    CAP_SJ, WR_SI, WR_SJ, RD_F, WAIT_F, CAP_F, WR_DEC, FINISH
  } state_t;

  localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(READ_WAIT - 1);
  localparam logic [AW-1:0] K_LAST    = AW'(MSG_LEN - 1);

  state_t        state;
  logic [7:0]    i, j, si, sj, f, e;
  logic [AW-1:0] k;
  logic [WW-1:0] wait_cnt;
  logic          legal;
  logic [7:0]    dec_byte;

  assign dec_byte = f ^ e;

  function automatic logic is_legal(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      done_flag   <= 1'b0;
      key_valid   <= 1'b0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      dec_address <= '0;
      dec_data    <= '0;
      dec_wren    <= 1'b0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      sj          <= '0;
      f           <= '0;
      e           <= '0;
      wait_cnt    <= '0;
      legal       <= 1'b0;
    end else begin
      s_wren   <= 1'b0;
      dec_wren <= 1'b0;
      unique case (state)
        IDLE: begin
          i <= '0;
          j <= '0;
          k <= '0;
          if (start_flag) state <= INC_I;
        end
        INC_I: begin
          i     <= i + 8'd1;
          state <= RD_SI;
        end
        RD_SI: begin
          s_address <= i;
          wait_cnt  <= WAIT_LAST;
          state     <= WAIT_SI;
        end
        WAIT_SI: begin
          if (wait_cnt == '0) state <= CAP_SI;
          else wait_cnt <= wait_cnt - WW'(1);
        end
        CAP_SI: begin
          si    <= s_data_read;
          state <= SET_J;
        end
        SET_J: begin
          j     <= j + si;
          state <= RD_SJ;
        end
        RD_SJ: begin
          s_address <= j;
          wait_cnt  <= WAIT_LAST;
          state     <= WAIT_SJ;
        end
        WAIT_SJ: begin
          if (wait_cnt == '0) state <= CAP_SJ;
          else wait_cnt <= wait_cnt - WW'(1);
        end
        CAP_SJ: begin
          sj    <= s_data_read;
          state <= WR_SI;
        end
        WR_SI: begin
          s_address <= i;
          s_data    <= sj;
          s_wren    <= 1'b1;
          state     <= WR_SJ;
        end
        WR_SJ: begin
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
          state     <= RD_F;
        end
        // si+sj is unchanged by the swap, so this read sees post-swap S
        RD_F: begin
          s_address   <= si + sj;
          rom_address <= k;
          wait_cnt    <= WAIT_LAST;
          state       <= WAIT_F;
        end
        WAIT_F: begin
          if (wait_cnt == '0) state <= CAP_F;
          else wait_cnt <= wait_cnt - WW'(1);
        end
        CAP_F: begin
          f     <= s_data_read;
          e     <= rom_data_read;
          state <= WR_DEC;
        end
        WR_DEC: begin
          dec_address <= k;
          dec_data    <= dec_byte;
          dec_wren    <= 1'b1;
          if (!is_legal(dec_byte)) begin
            legal <= 1'b0;
            state <= FINISH;
          end else if (k == K_LAST) begin
            legal <= 1'b1;
            state <= FINISH;
          end else begin
            k     <= k + AW'(1);
            state <= INC_I;
          end
        end
        FINISH: begin
          if (done_flag && !start_flag) begin
            done_flag <= 1'b0;
            key_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            done_flag <= 1'b1;
            key_valid <= legal;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
